riscv_wb_arbiter: RTL and testbench

Shares the register file's single write port (rd_we/rd_idx/rd_val) between two writeback producers: the ALU and the load/store unit.
- Each producer pushes results through a valid/ready handshake into its own small in-order buffer.
- A round-robin arbiter pops one buffered entry per cycle into a registered write port that drives riscv_register.
- Also reports whether a source register has a write still in flight, so the issue stage can stall on it.

---
 rtl/riscv_wb_arbiter_pkg.sv | 21 ++
 rtl/riscv_wb_fifo.sv | 80 ++++++++
 rtl/riscv_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_riscv_wb_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_arbiter_pkg.sv
// Shared widths, entry layout and grant encoding for the writeback arbiter.
package riscv_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;
    // Buffer entry layout: {idx, val}, with the destination index in the upper bits.
    localparam int ENTRY_W    = REG_ADDR_W + REG_W;

    // Identifies which producer received the most recent grant.
    typedef enum logic {
        WB_REQ_ALU = 1'b0,
        WB_REQ_LSU = 1'b1
    } wb_req_e;

    // Returns 1 when a query index names a real register (not x0) and matches a write target.
    function automatic logic idx_hit(input logic [REG_ADDR_W-1:0] query,
                                     input logic [REG_ADDR_W-1:0] target);
        return (query != '0) && (query == target);
    endfunction

endpackage

// File: rtl/riscv_wb_fifo.sv
// In-order buffer for one writeback producer. Exposes a per-entry valid bit and
// index so the top level can match hazard queries against every buffered write.
module riscv_wb_fifo
    import riscv_wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [ENTRY_W-1:0]          din,
    output logic [ENTRY_W-1:0]          dout,
    output logic [CNT_W-1:0]            count,
    output logic [DEPTH-1:0]            ent_vld,
    output logic [DEPTH*REG_ADDR_W-1:0] ent_idx
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   vld_q, vld_d;

    // Next-state for pointers, occupancy and per-entry valid bits.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        if (pop) begin
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            vld_d[wr_ptr_q] = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset empties the buffer and discards its contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Entry storage needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign ent_vld = vld_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_idx
        assign ent_idx[i*REG_ADDR_W +: REG_ADDR_W] = mem_q[i][ENTRY_W-1 -: REG_ADDR_W];
    end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Shares the register file write port between the ALU and the LSU. Each producer
// fills its own buffer; a round-robin arbiter drains one head per cycle into a
// registered write port, and hazard flags report any write still in flight.
module riscv_wb_arbiter
    import riscv_wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [REG_ADDR_W-1:0] alu_rd_idx_i,
    input  logic [REG_W-1:0]      alu_rd_val_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [REG_ADDR_W-1:0] lsu_rd_idx_i,
    input  logic [REG_W-1:0]      lsu_rd_val_i,
    output logic                  rd_we_o,
    output logic [REG_ADDR_W-1:0] rd_idx_o,
    output logic [REG_W-1:0]      rd_val_o,
    input  logic [REG_ADDR_W-1:0] rs1_idx_i,
    input  logic [REG_ADDR_W-1:0] rs2_idx_i,
    output logic                  rs1_pending_o,
    output logic                  rs2_pending_o
);

    logic [ENTRY_W-1:0]          alu_head, lsu_head;
    logic [CNT_W-1:0]            alu_cnt, lsu_cnt;
    logic [DEPTH-1:0]            alu_vld, lsu_vld;
    logic [DEPTH*REG_ADDR_W-1:0] alu_idx, lsu_idx;
    logic                        alu_push, lsu_push;
    logic                        alu_req, lsu_req;
    logic                        alu_gnt, lsu_gnt;

    logic                        rd_we_q, rd_we_d;
    logic [REG_ADDR_W-1:0]       rd_idx_q, rd_idx_d;
    logic [REG_W-1:0]            rd_val_q, rd_val_d;
    wb_req_e                     last_grant_q, last_grant_d;

    // Ready comes from the registered count only; a full buffer stays not-ready
    // even when it is popping this cycle. x0 writes complete the handshake but are dropped.
    assign alu_ready_o = rst_n && (alu_cnt < CNT_W'(DEPTH));
    assign lsu_ready_o = rst_n && (lsu_cnt < CNT_W'(DEPTH));
    assign alu_push    = alu_valid_i && alu_ready_o && (alu_rd_idx_i != '0);
    assign lsu_push    = lsu_valid_i && lsu_ready_o && (lsu_rd_idx_i != '0);

    riscv_wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (alu_push),
        .pop     (alu_gnt),
        .din     ({alu_rd_idx_i, alu_rd_val_i}),
        .dout    (alu_head),
        .count   (alu_cnt),
        .ent_vld (alu_vld),
        .ent_idx (alu_idx)
    );

    riscv_wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (lsu_push),
        .pop     (lsu_gnt),
        .din     ({lsu_rd_idx_i, lsu_rd_val_i}),
        .dout    (lsu_head),
        .count   (lsu_cnt),
        .ent_vld (lsu_vld),
        .ent_idx (lsu_idx)
    );

    // Round-robin grant on the current heads: under contention the side that did
    // not win last time goes first, so a starved head waits at most one cycle.
    assign alu_req = (alu_cnt != '0);
    assign lsu_req = (lsu_cnt != '0);
    assign alu_gnt = alu_req && (!lsu_req || (last_grant_q == WB_REQ_LSU));
    assign lsu_gnt = lsu_req && !alu_gnt;

    // Next-state for the write port; idx/val hold when nothing is granted.
    always_comb begin
        rd_we_d      = 1'b0;
        rd_idx_d     = rd_idx_q;
        rd_val_d     = rd_val_q;
        last_grant_d = last_grant_q;
        if (alu_gnt) begin
            rd_we_d      = 1'b1;
            rd_idx_d     = alu_head[ENTRY_W-1 -: REG_ADDR_W];
            rd_val_d     = alu_head[REG_W-1:0];
            last_grant_d = WB_REQ_ALU;
        end else if (lsu_gnt) begin
            rd_we_d      = 1'b1;
            rd_idx_d     = lsu_head[ENTRY_W-1 -: REG_ADDR_W];
            rd_val_d     = lsu_head[REG_W-1:0];
            last_grant_d = WB_REQ_LSU;
        end
    end

    // Registered write port and grant history; reset favours the ALU first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_we_q      <= 1'b0;
            rd_idx_q     <= '0;
            rd_val_q     <= '0;
            last_grant_q <= WB_REQ_LSU;
        end else begin
            rd_we_q      <= rd_we_d;
            rd_idx_q     <= rd_idx_d;
            rd_val_q     <= rd_val_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rd_we_o  = rd_we_q;
    assign rd_idx_o = rd_idx_q;
    assign rd_val_o = rd_val_q;

    // Hazard query: any valid buffered entry or the write currently on the port.
    always_comb begin
        rs1_pending_o = rd_we_q && idx_hit(rs1_idx_i, rd_idx_q);
        rs2_pending_o = rd_we_q && idx_hit(rs2_idx_i, rd_idx_q);
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_vld[i] && idx_hit(rs1_idx_i, alu_idx[i*REG_ADDR_W +: REG_ADDR_W])) rs1_pending_o = 1'b1;
            if (lsu_vld[i] && idx_hit(rs1_idx_i, lsu_idx[i*REG_ADDR_W +: REG_ADDR_W])) rs1_pending_o = 1'b1;
            if (alu_vld[i] && idx_hit(rs2_idx_i, alu_idx[i*REG_ADDR_W +: REG_ADDR_W])) rs2_pending_o = 1'b1;
            if (lsu_vld[i] && idx_hit(rs2_idx_i, lsu_idx[i*REG_ADDR_W +: REG_ADDR_W])) rs2_pending_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: per-source expected queues filled on
// accepted handshakes, compared against the writes seen on the register-file port.
module tb_riscv_wb_arbiter;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] val;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_idx_i = '0;
    logic [31:0] alu_rd_val_i = '0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_idx_i = '0;
    logic [31:0] lsu_rd_val_i = '0;
    logic        rd_we_o;
    logic [4:0]  rd_idx_o;
    logic [31:0] rd_val_o;
    logic [4:0]  rs1_idx_i = '0;
    logic [4:0]  rs2_idx_i = '0;
    logic        rs1_pending_o;
    logic        rs2_pending_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    wr_t exp_a[$];
    wr_t exp_l[$];
    wr_t wr_q[$];

    riscv_wb_arbiter #(.DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid_i   (alu_valid_i),
        .alu_ready_o   (alu_ready_o),
        .alu_rd_idx_i  (alu_rd_idx_i),
        .alu_rd_val_i  (alu_rd_val_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_rd_idx_i  (lsu_rd_idx_i),
        .lsu_rd_val_i  (lsu_rd_val_i),
        .rd_we_o       (rd_we_o),
        .rd_idx_o      (rd_idx_o),
        .rd_val_o      (rd_val_o),
        .rs1_idx_i     (rs1_idx_i),
        .rs2_idx_i     (rs2_idx_i),
        .rs1_pending_o (rs1_pending_o),
        .rs2_pending_o (rs2_pending_o)
    );

    always #5 clk = ~clk;

    // One clock: record accepted pushes into the model, then log any port write.
    task automatic tick();
        logic a_acc, l_acc;
        wr_t  e;
        #1;
        a_acc = alu_valid_i && alu_ready_o && (alu_rd_idx_i != 5'd0);
        l_acc = lsu_valid_i && lsu_ready_o && (lsu_rd_idx_i != 5'd0);
        @(posedge clk);
        if (!rst_n) begin
            exp_a.delete();
            exp_l.delete();
        end else begin
            if (a_acc) begin e.idx = alu_rd_idx_i; e.val = alu_rd_val_i; e.cyc = 0; exp_a.push_back(e); end
            if (l_acc) begin e.idx = lsu_rd_idx_i; e.val = lsu_rd_val_i; e.cyc = 0; exp_l.push_back(e); end
        end
        @(negedge clk);
        cyc++;
        if (rd_we_o) begin
            e.idx = rd_idx_o; e.val = rd_val_o; e.cyc = cyc;
            wr_q.push_back(e);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wr_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid_i = 1'b1; alu_rd_idx_i = 5'd7; alu_rd_val_i = 32'h0000_0777;
        rs1_idx_i = 5'd7;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (rd_we_o !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", rd_we_o); end
            checks++;
            if (alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin
                failures++; $display("FAIL reset_ready: got alu=%b lsu=%b want 0/0", alu_ready_o, lsu_ready_o);
            end
        end
        checks++;
        if (rd_idx_o !== 5'd0 || rd_val_o !== 32'd0) begin
            failures++; $display("FAIL reset_port: got idx=%0d val=%h want 0/0", rd_idx_o, rd_val_o);
        end
        alu_valid_i = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b1) begin
            failures++; $display("FAIL release_ready: got alu=%b lsu=%b want 1/1", alu_ready_o, lsu_ready_o);
        end
        wr_q.delete();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (wr_q.size() != 0) begin failures++; $display("FAIL reset_enqueue: got %0d writes want 0", wr_q.size()); end
        checks++;
        if (rs1_pending_o !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b want 0", rs1_pending_o); end
    endtask

    task automatic test_single();
        wr_t w, e;
        alu_valid_i = 1'b1; alu_rd_idx_i = 5'd5; alu_rd_val_i = 32'hDEAD_BEEF;
        rs1_idx_i = 5'd5;
        tick();
        alu_valid_i = 1'b0;
        checks++;
        if (rs1_pending_o !== 1'b1 || rd_we_o !== 1'b0) begin
            failures++; $display("FAIL single_t: got pend=%b we=%b want 1/0", rs1_pending_o, rd_we_o);
        end
        tick();
        checks++;
        if (rd_we_o !== 1'b1 || rd_idx_o !== 5'd5 || rd_val_o !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL single_write: got we=%b idx=%0d val=%h want 1/5/deadbeef", rd_we_o, rd_idx_o, rd_val_o);
        end
        checks++;
        if (rs1_pending_o !== 1'b1) begin failures++; $display("FAIL single_pend_port: got %b want 1", rs1_pending_o); end
        tick();
        checks++;
        if (rd_we_o !== 1'b0 || rs1_pending_o !== 1'b0) begin
            failures++; $display("FAIL single_done: got we=%b pend=%b want 0/0", rd_we_o, rs1_pending_o);
        end
        checks++;
        if (rd_idx_o !== 5'd5 || rd_val_o !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL single_hold: got idx=%0d val=%h want 5/deadbeef", rd_idx_o, rd_val_o);
        end
        while (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            checks++;
            if (exp_a.size() > 0 && exp_a[0].idx == w.idx) begin
                e = exp_a.pop_front();
                if (e.val !== w.val) begin failures++; $display("FAIL single_sb: got %h want %h", w.val, e.val); end
            end else begin
                failures++; $display("FAIL single_sb: got unexpected idx=%0d", w.idx);
            end
        end
        checks++;
        if (exp_a.size() != 0) begin failures++; $display("FAIL single_left: got %0d unwritten want 0", exp_a.size()); end
    endtask

    task automatic test_contention();
        logic [4:0] ord [4];
        wr_t w, e;
        ord[0] = 5'd1; ord[1] = 5'd3; ord[2] = 5'd2; ord[3] = 5'd4;
        reset_dut();
        alu_valid_i = 1'b1; alu_rd_idx_i = 5'd1; alu_rd_val_i = 32'hA1;
        lsu_valid_i = 1'b1; lsu_rd_idx_i = 5'd3; lsu_rd_val_i = 32'hB3;
        tick();
        alu_rd_idx_i = 5'd2; alu_rd_val_i = 32'hA2;
        lsu_rd_idx_i = 5'd4; lsu_rd_val_i = 32'hB4;
        tick();
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (wr_q.size() != 4) begin
            failures++; $display("FAIL cont_count: got %0d writes want 4", wr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_q[i].idx !== ord[i]) begin
                    failures++; $display("FAIL cont_order[%0d]: got idx=%0d want %0d", i, wr_q[i].idx, ord[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (wr_q[i].cyc != wr_q[i-1].cyc + 1) begin
                        failures++; $display("FAIL cont_gap[%0d]: got cycle %0d want %0d", i, wr_q[i].cyc, wr_q[i-1].cyc + 1);
                    end
                end
            end
        end
        while (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            checks++;
            if (exp_a.size() > 0 && exp_a[0].idx == w.idx) begin
                e = exp_a.pop_front();
                if (e.val !== w.val) begin failures++; $display("FAIL cont_sb: got %h want %h", w.val, e.val); end
            end else if (exp_l.size() > 0 && exp_l[0].idx == w.idx) begin
                e = exp_l.pop_front();
                if (e.val !== w.val) begin failures++; $display("FAIL cont_sb: got %h want %h", w.val, e.val); end
            end else begin
                failures++; $display("FAIL cont_sb: got unexpected idx=%0d", w.idx);
            end
        end
    endtask

    task automatic test_full();
        int ai, li;
        logic watch, seen, a_acc, l_acc;
        wr_t w, e;
        reset_dut();
        ai = 0; li = 0; watch = 1'b0; seen = 1'b0;
        for (int c = 0; c < 40 && (ai < 4 || li < 4); c++) begin
            alu_valid_i = (ai < 4); alu_rd_idx_i = 5'(20 + ai); alu_rd_val_i = 32'hA000_0000 + 32'(ai);
            lsu_valid_i = (li < 4); lsu_rd_idx_i = 5'(10 + li); lsu_rd_val_i = 32'hB000_0000 + 32'(li);
            #1;
            if (watch) begin
                checks++;
                if (lsu_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready: got %b want 0", lsu_ready_o); end
                watch = 1'b0;
                seen = 1'b1;
            end
            a_acc = alu_valid_i && alu_ready_o;
            l_acc = lsu_valid_i && lsu_ready_o;
            tick();
            if (a_acc) ai++;
            if (l_acc) begin li++; if (li == 2) watch = 1'b1; end
        end
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        checks++;
        if (ai != 4 || li != 4 || !seen) begin
            failures++; $display("FAIL full_progress: got alu=%0d lsu=%0d full_seen=%b want 4/4/1", ai, li, seen);
        end
        for (int i = 0; i < 8; i++) tick();
        while (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            checks++;
            if (exp_a.size() > 0 && exp_a[0].idx == w.idx) begin
                e = exp_a.pop_front();
                if (e.val !== w.val) begin failures++; $display("FAIL full_sb: got %h want %h", w.val, e.val); end
            end else if (exp_l.size() > 0 && exp_l[0].idx == w.idx) begin
                e = exp_l.pop_front();
                if (e.val !== w.val) begin failures++; $display("FAIL full_sb: got %h want %h", w.val, e.val); end
            end else begin
                failures++; $display("FAIL full_sb: got unexpected idx=%0d", w.idx);
            end
        end
        checks++;
        if (exp_a.size() + exp_l.size() != 0) begin
            failures++; $display("FAIL full_left: got %0d unwritten want 0", exp_a.size() + exp_l.size());
        end
    endtask

    task automatic test_x0_drop();
        wr_q.delete();
        alu_valid_i = 1'b1; alu_rd_idx_i = 5'd0; alu_rd_val_i = 32'h0000_1234;
        rs1_idx_i = 5'd0;
        #1;
        checks++;
        if (alu_ready_o !== 1'b1) begin failures++; $display("FAIL x0_ready: got %b want 1", alu_ready_o); end
        tick();
        alu_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_we_o !== 1'b0 || rs1_pending_o !== 1'b0) begin
                failures++; $display("FAIL x0_drop: got we=%b pend=%b want 0/0", rd_we_o, rs1_pending_o);
            end
            tick();
        end
        checks++;
        if (wr_q.size() != 0) begin failures++; $display("FAIL x0_write: got %0d writes want 0", wr_q.size()); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        rs1_idx_i = 5'd31; rs2_idx_i = 5'd41 - 5'd16;
        alu_valid_i = 1'b1; alu_rd_idx_i = 5'd30; alu_rd_val_i = 32'hC30;
        lsu_valid_i = 1'b1; lsu_rd_idx_i = 5'd24; lsu_rd_val_i = 32'hD24;
        tick();
        alu_rd_idx_i = 5'd31; alu_rd_val_i = 32'hC31;
        lsu_rd_idx_i = 5'd25; lsu_rd_val_i = 32'hD25;
        tick();
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        #1;
        checks++;
        if (rs1_pending_o !== 1'b1 || rs2_pending_o !== 1'b1) begin
            failures++; $display("FAIL mid_pend_before: got rs1=%b rs2=%b want 1/1", rs1_pending_o, rs2_pending_o);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (rd_idx_o !== 5'd0 || rd_val_o !== 32'd0) begin
            failures++; $display("FAIL mid_port: got idx=%0d val=%h want 0/0", rd_idx_o, rd_val_o);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rd_we_o !== 1'b0 || rs1_pending_o !== 1'b0 || rs2_pending_o !== 1'b0) begin
                failures++; $display("FAIL mid_after: got we=%b rs1=%b rs2=%b want 0/0/0", rd_we_o, rs1_pending_o, rs2_pending_o);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_x0_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
